// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the debug-unit instruction loader: default widths,
// the program terminator word and the loader state encoding.
package instruction_loader_pkg;

  localparam int DATA_BITS_DEF = 32;
  localparam int BYTE_BITS_DEF = 8;

  // All-zeros word doubles as the halt instruction and the end-of-program marker.
  localparam logic [DATA_BITS_DEF-1:0] TERMINATOR = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_END  = 2'd2
  } state_t;

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Packs UART bytes MSB-first into words; word/word_ready are combinational on the
// strobe that carries the last byte, so the word is usable on that same edge.
module instruction_loader_word_assembler
  import instruction_loader_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int BYTE_BITS = BYTE_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic [BYTE_BITS-1:0] rx_byte,
  output logic                 word_ready,
  output logic [DATA_BITS-1:0] word
);

  localparam int BYTES_PER_WORD = DATA_BITS / BYTE_BITS;
  localparam int IDX_BITS       = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(BYTES_PER_WORD - 1);

  logic [IDX_BITS-1:0]            byte_idx;
  // Only the already-received bytes are stored; the last byte comes straight from rx_byte.
  logic [DATA_BITS-BYTE_BITS-1:0] shreg;

  assign word       = {shreg, rx_byte};
  assign word_ready = shift_en && (byte_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      shreg    <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      shreg    <= '0;
    end else if (shift_en) begin
      byte_idx <= byte_idx + 1'b1;
      shreg    <= word[DATA_BITS-BYTE_BITS-1:0];
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Assembles debug-UART bytes into instruction words and writes them to the fetch stage.
// One-cycle write strobe after the 4th byte; session ends on the zero terminator or overflow.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int DATA_BITS         = DATA_BITS_DEF,
  parameter int BYTE_BITS         = BYTE_BITS_DEF,
  parameter int MEM_SIZE_IN_WORDS = 20
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic                                 i_start,
  input  logic                                 i_rx_valid,
  input  logic [BYTE_BITS-1:0]                 i_rx_byte,
  input  logic                                 i_full_mem,
  output logic                                 o_write_mem,
  output logic [DATA_BITS-1:0]                 o_instruction,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_overflow,
  output logic [$clog2(MEM_SIZE_IN_WORDS+1)-1:0] o_word_count
);

  localparam int CNT_BITS = $clog2(MEM_SIZE_IN_WORDS + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(MEM_SIZE_IN_WORDS);

  state_t               state;
  state_t               state_nxt;
  logic                 start_session;
  logic                 shift_en;
  logic                 word_ready;
  logic                 word_is_term;
  logic [DATA_BITS-1:0] word;

  // i_start is only honoured outside LOAD, so a session cannot restart mid-word.
  assign start_session = i_start && (state != ST_LOAD);
  assign shift_en      = i_rx_valid && (state == ST_LOAD);
  assign word_is_term  = (word == DATA_BITS'(TERMINATOR));
  assign o_busy        = (state == ST_LOAD);

  instruction_loader_word_assembler #(
    .DATA_BITS (DATA_BITS),
    .BYTE_BITS (BYTE_BITS)
  ) word_assembler (
    .clk        (i_clk),
    .rst_n      (i_reset),
    .clear      (start_session),
    .shift_en   (shift_en),
    .rx_byte    (i_rx_byte),
    .word_ready (word_ready),
    .word       (word)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_END: begin
        if (i_start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (word_ready && (word_is_term || i_full_mem)) state_nxt = ST_END;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_write_mem   <= 1'b0;
      o_instruction <= '0;
      o_done        <= 1'b0;
      o_overflow    <= 1'b0;
      o_word_count  <= '0;
    end else begin
      o_write_mem <= 1'b0;
      if (start_session) begin
        o_done       <= 1'b0;
        o_overflow   <= 1'b0;
        o_word_count <= '0;
      end else if (word_ready) begin
        if (!i_full_mem) begin
          o_write_mem   <= 1'b1;
          o_instruction <= word;
          if (o_word_count != CNT_MAX) o_word_count <= o_word_count + 1'b1;
        end
        // A terminator is a clean finish even when it could not be stored.
        if (word_is_term) begin
          o_done <= 1'b1;
        end else if (i_full_mem) begin
          o_overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: byte streams with hand-computed words,
// flags and counts; write strobes are captured into a queue for comparison.
module tb_instruction_loader;

  localparam int DATA_BITS = 32;
  localparam int BYTE_BITS = 8;
  localparam int MEM_WORDS = 20;
  localparam int CW        = $clog2(MEM_WORDS + 1);

  logic                 i_clk;
  logic                 i_reset;
  logic                 i_start;
  logic                 i_rx_valid;
  logic [BYTE_BITS-1:0] i_rx_byte;
  logic                 i_full_mem;
  logic                 o_write_mem;
  logic [DATA_BITS-1:0] o_instruction;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_overflow;
  logic [CW-1:0]        o_word_count;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] wr_q[$];
  logic [31:0] b2b_q[$];

  instruction_loader #(
    .DATA_BITS         (DATA_BITS),
    .BYTE_BITS         (BYTE_BITS),
    .MEM_SIZE_IN_WORDS (MEM_WORDS)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_rx_valid    (i_rx_valid),
    .i_rx_byte     (i_rx_byte),
    .i_full_mem    (i_full_mem),
    .o_write_mem   (o_write_mem),
    .o_instruction (o_instruction),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_overflow    (o_overflow),
    .o_word_count  (o_word_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_write_mem === 1'b1) wr_q.push_back(o_instruction);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wr_at(input int idx);
    if (idx < wr_q.size()) return wr_q[idx];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic pulse_start();
    @(negedge i_clk) i_start = 1'b1;
    @(negedge i_clk) i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_valid = 1'b1;
    i_rx_byte  = b;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
  endtask

  // Every byte of every queued word on consecutive cycles.
  task automatic flush_b2b();
    foreach (b2b_q[k]) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge i_clk);
        i_rx_valid = 1'b1;
        i_rx_byte  = b2b_q[k][31-8*i -: 8];
      end
    end
    @(negedge i_clk);
    i_rx_valid = 1'b0;
    b2b_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset    = 1'b0;
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_byte  = '0;
    i_full_mem = 1'b0;
    tick(3);
    check("rst_write", 32'(o_write_mem), 32'd0);
    check("rst_instr", o_instruction, 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_ovf", 32'(o_overflow), 32'd0);
    check("rst_count", 32'(o_word_count), 32'd0);
    @(negedge i_clk) i_reset = 1'b1;

    // Bytes while idle must not be captured.
    send_byte(8'h11);
    send_byte(8'h22);
    tick(1);
    check("idle_busy", 32'(o_busy), 32'd0);
    check("idle_nowrite", 32'(wr_q.size()), 32'd0);

    pulse_start();
    check("start_busy", 32'(o_busy), 32'd1);
    send_word(32'h1234_5678);
    tick(2);
    check("w1_writes", 32'(wr_q.size()), 32'd1);
    check("w1_data", wr_at(0), 32'h1234_5678);
    check("w1_count", 32'(o_word_count), 32'd1);
    check("w1_strobe_low", 32'(o_write_mem), 32'd0);
    check("w1_instr_hold", o_instruction, 32'h1234_5678);

    // i_start mid-word is ignored.
    send_byte(8'hAB);
    send_byte(8'hCD);
    pulse_start();
    send_byte(8'hEF);
    send_byte(8'h01);
    tick(2);
    check("w2_writes", 32'(wr_q.size()), 32'd2);
    check("w2_data", wr_at(1), 32'hABCD_EF01);
    check("w2_count", 32'(o_word_count), 32'd2);

    send_word(32'h0);
    tick(2);
    check("t1_writes", 32'(wr_q.size()), 32'd3);
    check("t1_data", wr_at(2), 32'h0);
    check("t1_done", 32'(o_done), 32'd1);
    check("t1_busy", 32'(o_busy), 32'd0);
    check("t1_count", 32'(o_word_count), 32'd3);
    check("t1_ovf", 32'(o_overflow), 32'd0);

    // Back-to-back stream, new session clears flags.
    wr_q.delete();
    pulse_start();
    check("s2_done_clr", 32'(o_done), 32'd0);
    check("s2_count_clr", 32'(o_word_count), 32'd0);
    b2b_q = '{32'h0102_0304, 32'h0A0B_0C0D, 32'hFFFF_FFFF, 32'h0};
    flush_b2b();
    tick(2);
    check("b2b_writes", 32'(wr_q.size()), 32'd4);
    check("b2b_w0", wr_at(0), 32'h0102_0304);
    check("b2b_w1", wr_at(1), 32'h0A0B_0C0D);
    check("b2b_w2", wr_at(2), 32'hFFFF_FFFF);
    check("b2b_w3", wr_at(3), 32'h0);
    check("b2b_done", 32'(o_done), 32'd1);
    check("b2b_busy", 32'(o_busy), 32'd0);
    check("b2b_count", 32'(o_word_count), 32'd4);
    send_word(32'hCAFE_F00D);
    tick(2);
    check("end_nowrite", 32'(wr_q.size()), 32'd4);
    check("end_count", 32'(o_word_count), 32'd4);

    // Overflow: non-terminator with memory full.
    wr_q.delete();
    pulse_start();
    i_full_mem = 1'b1;
    send_word(32'hDEAD_BEEF);
    tick(2);
    i_full_mem = 1'b0;
    check("ovf_nowrite", 32'(wr_q.size()), 32'd0);
    check("ovf_flag", 32'(o_overflow), 32'd1);
    check("ovf_done", 32'(o_done), 32'd0);
    check("ovf_busy", 32'(o_busy), 32'd0);
    check("ovf_count", 32'(o_word_count), 32'd0);

    // Reset mid-word discards the partial word.
    pulse_start();
    check("s4_ovf_clr", 32'(o_overflow), 32'd0);
    send_byte(8'h55);
    send_byte(8'h66);
    @(negedge i_clk) i_reset = 1'b0;
    #1;
    check("mrst_busy", 32'(o_busy), 32'd0);
    check("mrst_instr", o_instruction, 32'd0);
    @(negedge i_clk) i_reset = 1'b1;
    tick(2);
    check("mrst_nowrite", 32'(wr_q.size()), 32'd0);
    pulse_start();
    send_word(32'hAABB_CCDD);
    tick(2);
    check("mrst_writes", 32'(wr_q.size()), 32'd1);
    check("mrst_data", wr_at(0), 32'hAABB_CCDD);
    check("mrst_count", 32'(o_word_count), 32'd1);
    send_word(32'h0);
    tick(2);

    // Fill memory, then terminator arrives with memory full.
    wr_q.delete();
    pulse_start();
    for (int i = 1; i <= MEM_WORDS; i++) b2b_q.push_back(32'h1000_0000 + 32'(i));
    flush_b2b();
    i_full_mem = 1'b1;
    send_word(32'h0);
    tick(2);
    i_full_mem = 1'b0;
    check("cap_writes", 32'(wr_q.size()), 32'(MEM_WORDS));
    for (int i = 0; i < MEM_WORDS; i++)
      check($sformatf("cap_w%0d", i), wr_at(i), 32'h1000_0000 + 32'(i + 1));
    check("cap_done", 32'(o_done), 32'd1);
    check("cap_ovf", 32'(o_overflow), 32'd0);
    check("cap_busy", 32'(o_busy), 32'd0);
    check("cap_count", 32'(o_word_count), 32'(MEM_WORDS));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Upstream feeder of the instruction-fetch stage. It turns the byte stream delivered by the UART receiver of the debug unit into 32-bit instruction words and writes them into the fetch stage's instruction memory through its `i_write_mem`/`i_instruction` port pair. A load session is armed by the debug unit and ends on the all-zeros terminator word or on memory overflow. Completion is reported back to the debug unit so it can start execution.

## Interface
Parameters:
- `DATA_BITS`, 32: instruction word width; must equal the architecture width.
- `BYTE_BITS`, 8: UART byte width.
- `MEM_SIZE_IN_WORDS`, 20: instruction memory depth; sizes the word counter.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  one-cycle pulse; opens a load session.
- `i_rx_valid`  in  1  one-cycle strobe; `i_rx_byte` is valid.
- `i_rx_byte`  in  `BYTE_BITS`  received byte.
- `i_full_mem`  in  1  instruction memory full (`o_full_mem` of the fetch stage).
- `o_write_mem`  out  1  one-cycle write strobe to the fetch stage.
- `o_instruction`  out  `DATA_BITS`  assembled word; stable while `o_write_mem` is high.
- `o_busy`  out  1  session open.
- `o_done`  out  1  sticky; terminator seen.
- `o_overflow`  out  1  sticky; a non-terminator word arrived while memory was full.
- `o_word_count`  out  `$clog2(MEM_SIZE_IN_WORDS+1)`  words written this session, terminator included.

## Operation
- The state machine has three states: IDLE, LOAD and END.
- IDLE:
  - `i_start` moves the block to LOAD.
  - On that transition, clear the byte index, the assembly register, `o_word_count`, `o_done` and `o_overflow`.
  - `i_rx_valid` is ignored.
- LOAD (`o_busy`=1):
  - Each `i_rx_valid` shifts the byte in, first byte first: byte 0 goes to bits 31:24 and byte 3 to bits 7:0.
  - The 2-bit byte index wraps from 3 to 0.
  - On the 4th byte, the word is complete and one of the following applies:
    - Word ≠ 0 and `i_full_mem`=0: register the word into `o_instruction`, pulse `o_write_mem`, increment `o_word_count`, stay in LOAD.
    - Word ≠ 0 and `i_full_mem`=1: no write, set `o_overflow`, go to END.
    - Word = 0 and `i_full_mem`=0: write it as the halt/terminator, increment the count, set `o_done`, go to END.
    - Word = 0 and `i_full_mem`=1: no write, set `o_done`, go to END.
- END (`o_busy`=0): hold all flags and the count. Bytes are ignored. `i_start` re-enters LOAD and clears the flags.
- `i_start` while in LOAD is ignored; there is no restart mid-word.
- The count saturates at `MEM_SIZE_IN_WORDS`.

## Timing
- Reset values:
  - State IDLE.
  - `o_write_mem`=0, `o_instruction`=0, `o_busy`=0, `o_done`=0, `o_overflow`=0, `o_word_count`=0.
  - Byte index 0.
- Latency:
  - `o_write_mem` is high exactly one cycle, in the cycle after the edge that samples the 4th `i_rx_valid`.
  - `o_word_count`, `o_done` and `o_overflow` update on that same edge.
- `i_full_mem` is sampled on the edge that samples the 4th byte.
- `o_busy` rises on the cycle after `i_start` and falls together with `o_done`/`o_overflow` rising.
- Back-to-back `i_rx_valid` on consecutive cycles is legal. A new word's first byte may arrive in the same cycle `o_write_mem` is high. `o_instruction` holds its value until the next word is complete.
- Reset asserted mid-session returns the block to IDLE immediately. A partial word is discarded, and no `o_write_mem` pulse follows.

## Structure
- Shared pipeline package holds `DATA_BITS`/`BYTE_BITS` defaults, the terminator constant (32'h0000_0000) and the state encoding.
- One natural sub-module, `word_assembler`:
  - Holds the shift register and byte index.
  - Outputs `word_ready` and `word`.
- FSM, flags and counter live in `instruction_loader`.

## Test plan
- Reset → all outputs 0. Then `i_start`, then bytes 12 34 56 78 → one `o_write_mem` pulse with `o_instruction`=32'h12345678 and `o_word_count`=1.
- Stream 3 words + terminator 00 00 00 00, with bytes back-to-back → 4 write pulses, the last with 32'h0, then `o_done`=1, `o_busy`=0, count=4.
- Hold `i_full_mem`=1, then send word 32'hDEADBEEF → no write, `o_overflow`=1, `o_done`=0, state END.
- Reset mid-word after 2 bytes, then `i_start` and 4 bytes AA BB CC DD → the written word is 32'hAABBCCDD; no leftover bytes appear.
- Bytes before `i_start`, and `i_start` during LOAD → ignored; the word sequence is unaffected.
- `MEM_SIZE_IN_WORDS`=20: 20 nonzero words, then the terminator with `i_full_mem`=1 → 20 writes, `o_done`=1, count=20.
